uart_rx_controller: RTL and testbench

UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

---
 rtl/uart_rx_controller_if.sv | 35 +++
 rtl/uart_rx_controller.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_controller.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_controller_if.sv
// Signal bundle between the UART receive controller and its sampler/checker sub-blocks.
// The controller takes the slave modport; the surrounding datapath or bench takes master.
interface uart_rx_controller_if;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic       start_glitch;
  logic       parity_error;
  logic       stop_error;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       data_sampler_enable;
  logic       start_checker_enable;
  logic       deserializer_enable;
  logic       parity_checker_enable;
  logic       stop_checker_enable;
  logic       data_valid;
  logic       frame_err;
  logic       par_err;
  logic [7:0] err_count;

  modport master (
    output RX_IN, PAR_EN, Prescale, start_glitch, parity_error, stop_error,
    input  edge_cnt, bit_cnt, data_sampler_enable, start_checker_enable,
           deserializer_enable, parity_checker_enable, stop_checker_enable,
           data_valid, frame_err, par_err, err_count
  );

  modport slave (
    input  RX_IN, PAR_EN, Prescale, start_glitch, parity_error, stop_error,
    output edge_cnt, bit_cnt, data_sampler_enable, start_checker_enable,
           deserializer_enable, parity_checker_enable, stop_checker_enable,
           data_valid, frame_err, par_err, err_count
  );
endinterface

// File: rtl/uart_rx_controller.sv
// UART receive frame controller: bit/edge timing, sub-block enables and end-of-frame status.
// Optional saturating error counter is built only when UART_RX_ERR_CNT_EN is defined.
module uart_rx_controller #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic                 CLK,
  input logic                 RST,
  uart_rx_controller_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e     state_q, state_d;
  logic [5:0] edge_q, edge_d;
  logic [3:0] bit_q, bit_d;
  logic [5:0] p_q, p_d;
  logic       pe_q, pe_d;
  logic       plat_q, plat_d;
  logic       dv_q, dv_d;
  logic       fe_q, fe_d;
  logic       perr_q, perr_d;
  logic       bit_end;
  logic [5:0] presc_cap;

  logic en_sampler, en_start, en_deser, en_parity, en_stop;

  assign bit_end = (edge_q == (p_q - 6'd1));

  // Unsupported oversampling ratios fall back to 8.
  always_comb begin
    case (bus.Prescale)
      6'd16:   presc_cap = 6'd16;
      6'd32:   presc_cap = 6'd32;
      default: presc_cap = 6'd8;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      p_q     <= 6'd8;
      pe_q    <= 1'b0;
      plat_q  <= 1'b0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      p_q     <= p_d;
      pe_q    <= pe_d;
      plat_q  <= plat_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    p_d     = p_q;
    pe_d    = pe_q;
    plat_d  = plat_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    perr_d  = 1'b0;
    if (state_q == IDLE) begin
      edge_d = '0;
      bit_d  = '0;
      if (!bus.RX_IN) begin
        state_d = START;
        p_d     = presc_cap;
        pe_d    = bus.PAR_EN;
        plat_d  = 1'b0;
      end
    end else begin
      edge_d = bit_end ? '0 : edge_q + 6'd1;
      if (bit_end) begin
        bit_d = bit_q + 4'd1;
        case (state_q)
          START: begin
            if (bus.start_glitch) begin
              state_d = IDLE;
              bit_d   = '0;
            end else begin
              state_d = DATA;
            end
          end
          DATA: begin
            if (bit_q == 4'(DATA_WIDTH)) state_d = pe_q ? PARITY : STOP;
          end
          PARITY: begin
            state_d = STOP;
            plat_d  = bus.parity_error;
          end
          STOP: begin
            state_d = IDLE;
            bit_d   = '0;
            fe_d    = bus.stop_error;
            perr_d  = plat_q;
            dv_d    = !bus.stop_error && !plat_q;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    en_sampler = 1'b0;
    en_start   = 1'b0;
    en_deser   = 1'b0;
    en_parity  = 1'b0;
    en_stop    = 1'b0;
    case (state_q)
      START:  begin en_sampler = 1'b1; en_start = 1'b1; end
      DATA:   begin en_sampler = 1'b1; en_deser = 1'b1; en_parity = 1'b1; end
      PARITY: begin en_sampler = 1'b1; en_parity = 1'b1; end
      STOP:   begin en_sampler = 1'b1; en_stop = 1'b1; end
      default: ;
    endcase
  end

  assign bus.edge_cnt              = edge_q;
  assign bus.bit_cnt               = bit_q;
  assign bus.data_sampler_enable   = en_sampler;
  assign bus.start_checker_enable  = en_start;
  assign bus.deserializer_enable   = en_deser;
  assign bus.parity_checker_enable = en_parity;
  assign bus.stop_checker_enable   = en_stop;
  assign bus.data_valid            = dv_q;
  assign bus.frame_err             = fe_q;
  assign bus.par_err               = perr_q;

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] errc_q;
  logic       abort;

  // Error pulses and start aborts are never in the same cycle, so +1 suffices.
  assign abort = (state_q == START) && bit_end && bus.start_glitch;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      errc_q <= '0;
    end else if ((fe_q || perr_q || abort) && (errc_q != '1)) begin
      errc_q <= errc_q + 8'd1;
    end
  end

  assign bus.err_count = errc_q;
`else
  assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller: a scoreboard holds the expected status pulse
// (kind and cycle) of every started frame; a negedge monitor pops and compares them.
module tb_uart_rx_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_rx_controller_if u_if();

  uart_rx_controller #(.DATA_WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (u_if.slave)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  kind;
    int unsigned at;
  } exp_t;
  exp_t sb[$];

  localparam logic [2:0] K_DV = 3'b100;
  localparam logic [2:0] K_FE = 3'b010;
  localparam logic [2:0] K_PE = 3'b001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] errexp(input int unsigned n);
`ifdef UART_RX_ERR_CNT_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  function automatic int unsigned eff_p(input logic [5:0] p);
    return (p == 6'd16) ? 16 : (p == 6'd32) ? 32 : 8;
  endfunction

  function automatic logic [4:0] enables();
    return {u_if.data_sampler_enable, u_if.start_checker_enable, u_if.deserializer_enable,
            u_if.parity_checker_enable, u_if.stop_checker_enable};
  endfunction

  function automatic logic [31:0] all_outs();
    return {14'd0, u_if.edge_cnt, u_if.bit_cnt, enables(),
            u_if.data_valid, u_if.frame_err, u_if.par_err};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && (u_if.data_valid | u_if.frame_err | u_if.par_err) === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {29'd0, u_if.data_valid, u_if.frame_err, u_if.par_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {29'd0, u_if.data_valid, u_if.frame_err, u_if.par_err}, {29'd0, e.kind});
        chk("pulse_cycle", cyc, e.at);
      end
    end
  end

  task automatic drive_at(input int unsigned t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample_at(input int unsigned t);
    drive_at(t);
    @(negedge clk);
  endtask

  // Drops RX_IN for one cycle; the next edge is the START-entry edge.
  task automatic start_frame(input logic [5:0] presc, input logic pe, input logic [2:0] kind,
                             input bit expect_pulse, output int unsigned entry);
    exp_t e;
    u_if.Prescale = presc;
    u_if.PAR_EN   = pe;
    u_if.RX_IN    = 1'b0;
    entry = cyc + 1;
    if (expect_pulse) begin
      e.kind = kind;
      e.at   = entry + (8 + 2 + int'(pe)) * eff_p(presc);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    u_if.RX_IN = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned e, e2;
    rst_n             = 1'b0;
    u_if.RX_IN        = 1'b1;
    u_if.PAR_EN       = 1'b0;
    u_if.Prescale     = 6'd8;
    u_if.start_glitch = 1'b0;
    u_if.parity_error = 1'b0;
    u_if.stop_error   = 1'b0;

    #12;
    chk("reset_outputs", all_outs(), 32'd0);
    chk("reset_errcnt", {24'd0, u_if.err_count}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sample_at(cyc + 2);
    chk("idle_no_start", all_outs(), 32'd0);

    // Frame 1: P=8, parity on, clean -> data_valid at 88
    drive_at(cyc + 1);
    start_frame(6'd8, 1'b1, K_DV, 1'b1, e);
    sample_at(e);
    chk("f1_start_en", {27'd0, enables()}, 32'b11000);
    chk("f1_start_cnt", {22'd0, u_if.edge_cnt, u_if.bit_cnt}, 32'd0);
    sample_at(e + 5);
    chk("f1_edge5", {26'd0, u_if.edge_cnt}, 32'd5);
    sample_at(e + 8);
    chk("f1_data_en", {27'd0, enables()}, 32'b10110);
    chk("f1_bit1", {22'd0, u_if.edge_cnt, u_if.bit_cnt}, {22'd0, 6'd0, 4'd1});
    sample_at(e + 72);
    chk("f1_parity_en", {27'd0, enables()}, 32'b10010);
    chk("f1_bit9", {28'd0, u_if.bit_cnt}, 32'd9);
    sample_at(e + 80);
    chk("f1_stop_en", {27'd0, enables()}, 32'b10001);
    chk("f1_bit10", {28'd0, u_if.bit_cnt}, 32'd10);
    sample_at(e + 89);
    chk("f1_after_idle", all_outs(), 32'd0);
    chk("f1_errcnt", {24'd0, u_if.err_count}, errexp(0));

    // Frame 2: P=16, no parity, stop error -> frame_err at 160
    u_if.stop_error = 1'b1;
    start_frame(6'd16, 1'b0, K_FE, 1'b1, e);
    sample_at(e + 161);
    chk("f2_errcnt", {24'd0, u_if.err_count}, errexp(1));
    u_if.stop_error = 1'b0;

    // Frame 3: start glitch -> abort, no pulse
    u_if.start_glitch = 1'b1;
    start_frame(6'd8, 1'b0, 3'd0, 1'b0, e);
    sample_at(e + 7);
    chk("f3_start_en", {27'd0, enables()}, 32'b11000);
    sample_at(e + 8);
    chk("f3_abort_idle", all_outs(), 32'd0);
    sample_at(e + 9);
    chk("f3_errcnt", {24'd0, u_if.err_count}, errexp(2));
    u_if.start_glitch = 1'b0;
    sample_at(e + 100);

    // Frame 4: Prescale=20 runs at 8; mid-frame config changes ignored
    drive_at(cyc + 1);
    start_frame(6'd20, 1'b0, K_DV, 1'b1, e);
    u_if.Prescale = 6'd32;
    u_if.PAR_EN   = 1'b1;
    sample_at(e + 8);
    chk("f4_bit1_p8", {22'd0, u_if.edge_cnt, u_if.bit_cnt}, {22'd0, 6'd0, 4'd1});
    sample_at(e + 82);

    // Frame 5a: parity error only; 5b: parity and stop error together
    drive_at(cyc + 1);
    u_if.parity_error = 1'b1;
    start_frame(6'd8, 1'b1, K_PE, 1'b1, e);
    sample_at(e + 90);
    chk("f5a_errcnt", {24'd0, u_if.err_count}, errexp(3));
    u_if.stop_error = 1'b1;
    drive_at(cyc + 1);
    start_frame(6'd8, 1'b1, K_FE | K_PE, 1'b1, e);
    sample_at(e + 90);
    chk("f5b_errcnt", {24'd0, u_if.err_count}, errexp(4));
    u_if.parity_error = 1'b0;
    u_if.stop_error   = 1'b0;

    // Frame 6: reset in DATA at bit 4, then a clean frame
    drive_at(cyc + 1);
    start_frame(6'd8, 1'b0, K_DV, 1'b1, e);
    sample_at(e + 32);
    chk("f6_bit4", {22'd0, u_if.edge_cnt, u_if.bit_cnt}, {22'd0, 6'd0, 4'd4});
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("f6_async_reset", all_outs(), 32'd0);
    chk("f6_reset_errcnt", {24'd0, u_if.err_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sample_at(cyc + 3);
    chk("f6_post_reset_idle", all_outs(), 32'd0);
    drive_at(cyc + 1);
    start_frame(6'd8, 1'b0, K_DV, 1'b1, e);
    sample_at(e + 82);

    // Frames 7a/7b: back-to-back, second start in the pulse (first IDLE) cycle
    drive_at(cyc + 1);
    start_frame(6'd16, 1'b1, K_DV, 1'b1, e);
    drive_at(e + 176);
    start_frame(6'd16, 1'b1, K_DV, 1'b1, e2);
    chk("f7_second_entry", e2, e + 177);
    sample_at(e2 + 178);
    chk("f7_errcnt", {24'd0, u_if.err_count}, 32'd0);

    repeat (20) @(posedge clk);
    chk("missing_pulses", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
